// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   scan_state_t : debounce FSM states
//   scan_class_t : classification of one complete four-column scan
//   KEYMAP       : hex code per key, indexed {row[1:0], col[1:0]}
//   count_hits   : population count of a 16-bit hit map
package keypad_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } scan_state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } scan_class_t;

   // Element 0 is row 0 / column 0, element 15 is row 3 / column 3.
   localparam logic [15:0][3:0] KEYMAP = {
      4'hD, 4'hE, 4'hF, 4'h0,    // row 3, cols 3..0
      4'hC, 4'h9, 4'h8, 4'h7,    // row 2
      4'hB, 4'h6, 4'h5, 4'h4,    // row 1
      4'hA, 4'h3, 4'h2, 4'h1     // row 0
   };

   function automatic logic [4:0] count_hits(input logic [15:0] hits);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, hits[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: user-side signals of the keypad scanner.
//   clear       : synchronous clear of the entry register (into the scanner)
//   key_valid   : one-cycle pulse per accepted press
//   key_code    : hex code of the last accepted key
//   key_pressed : level, high while a debounced key is held
//   value       : 16-bit entry register, newest nibble at the LSB end
// master = the scanner, slave = the consumer.
interface keypad_scanner_if;
   logic        clear;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_pressed;
   logic [15:0] value;

   modport master (
      input  clear,
      output key_valid,
      output key_code,
      output key_pressed,
      output value
   );

   modport slave (
      output clear,
      input  key_valid,
      input  key_code,
      input  key_pressed,
      input  value
   );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer with a synchronous reset value.
//   clk  : destination clock
//   srst : synchronous active-high reset, loads RESET_VALUE into both flops
//   d    : asynchronous input
//   q    : synchronized output, two cycles behind d
module sync_2ff #(
   parameter int                WIDTH       = 4,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces whole
// scans and shifts accepted hex codes into a 16-bit entry register.
//   clk_100 : system clock
//   reset   : synchronous active-high reset
//   ROW     : keypad rows, active-low, asynchronous
//   COL     : column strobes, active-low, one-cold
//   kp      : user side (clear in; key_valid, key_code, key_pressed, value out)
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 100_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic               clk_100,
   input  logic               reset,
   input  logic [3:0]         ROW,
   output logic [3:0]         COL,
   keypad_scanner_if.master   kp
);

   localparam int              TW        = $clog2(SCAN_TICKS);
   localparam logic [TW-1:0]   TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam int              NW        = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [NW-1:0]   N_DONE    = NW'(DEBOUNCE_SCANS);

   logic [3:0]  row_sync;

   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    col_q, col_d;
   logic [15:0]   hit_q, hit_d;
   scan_state_t   state_q, state_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_pressed_q, key_pressed_d;
   logic [15:0]   value_q, value_d;

   logic [3:0]  col_onehot;
   logic [15:0] col_hits;
   logic [15:0] scan_hits;
   logic        col_last;
   logic        scan_end;
   scan_class_t scan_class;
   logic [3:0]  scan_code;
   logic        accept;

   sync_2ff #(.WIDTH(4), .RESET_VALUE(4'hF)) u_row_sync (
      .clk  (clk_100),
      .srst (reset),
      .d    (ROW),
      .q    (row_sync)
   );

   assign col_onehot = 4'b0001 << col_q;
   assign COL        = ~col_onehot;
   assign col_last   = (tick_q == TICK_LAST);
   assign scan_end   = col_last && (col_q == 2'd3);

   // Hits seen in the active column, placed at their {row, col} positions.
   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign col_hits[gi*4 +: 4] = row_sync[gi] ? 4'b0000 : col_onehot;
   end

   // Column 3 is not yet in hit_q on the scan's last tick, so merge it here.
   assign scan_hits = hit_q | col_hits;

   always_comb begin
      scan_code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (scan_hits[i]) begin
            scan_code = KEYMAP[i];
         end
      end
      case (count_hits(scan_hits))
         5'd0:    scan_class = NONE;
         5'd1:    scan_class = SINGLE;
         default: scan_class = MULTI;
      endcase
   end

   // Scan timing and hit accumulation.
   always_comb begin
      tick_d = tick_q + TW'(1);
      col_d  = col_q;
      hit_d  = hit_q;
      if (col_last) begin
         tick_d = '0;
         col_d  = col_q + 2'd1;
         hit_d  = scan_end ? 16'h0000 : scan_hits;
      end
   end

   // Debounce FSM, stepped once per completed scan. MULTI behaves as NONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      if (scan_end) begin
         case (state_q)
            RELEASED: begin
               if (scan_class == SINGLE) begin
                  cand_d = scan_code;
                  cnt_d  = NW'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept  = 1'b1;
                     state_d = PRESSED;
                  end else begin
                     state_d = PRESS_WAIT;
                  end
               end
            end
            PRESS_WAIT: begin
               if (scan_class == SINGLE) begin
                  if (scan_code == cand_q) begin
                     cnt_d = cnt_q + NW'(1);
                     if ((cnt_q + NW'(1)) == N_DONE) begin
                        accept  = 1'b1;
                        state_d = PRESSED;
                     end
                  end else begin
                     cand_d = scan_code;
                     cnt_d  = NW'(1);
                  end
               end else begin
                  state_d = RELEASED;
               end
            end
            PRESSED: begin
               if (scan_class != SINGLE) begin
                  cnt_d = NW'(1);
                  // With single-scan debounce the first NONE already completes the release.
                  state_d = (DEBOUNCE_SCANS == 1) ? RELEASED : RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (scan_class == SINGLE) begin
                  state_d = PRESSED;
               end else begin
                  cnt_d = cnt_q + NW'(1);
                  if ((cnt_q + NW'(1)) == N_DONE) begin
                     state_d = RELEASED;
                  end
               end
            end
            default: state_d = RELEASED;
         endcase
      end
   end

   // Output registers; clear takes priority over a coinciding accept.
   always_comb begin
      key_valid_d   = accept;
      key_code_d    = accept ? scan_code : key_code_q;
      key_pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      value_d       = value_q;
      if (kp.clear) begin
         value_d = 16'h0000;
      end else if (accept) begin
         value_d = {value_q[11:0], scan_code};
      end
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         tick_q        <= '0;
         col_q         <= 2'd0;
         hit_q         <= 16'h0000;
         state_q       <= RELEASED;
         cnt_q         <= '0;
         cand_q        <= 4'h0;
         key_valid_q   <= 1'b0;
         key_code_q    <= 4'h0;
         key_pressed_q <= 1'b0;
         value_q       <= 16'h0000;
      end else begin
         tick_q        <= tick_d;
         col_q         <= col_d;
         hit_q         <= hit_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_q        <= cand_d;
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         key_pressed_q <= key_pressed_d;
         value_q       <= value_d;
      end
   end

   assign kp.key_valid   = key_valid_q;
   assign kp.key_code    = key_code_q;
   assign kp.key_pressed = key_pressed_q;
   assign kp.value       = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed stimulus for keypad_scanner,
// checked every cycle against a scan-level behavioural model, plus literal
// expectations for the directed scenarios.
module tb_keypad_scanner;

   localparam int ST   = 8;
   localparam int DS   = 2;
   localparam int SCAN = 4 * ST;

   logic        clk_100 = 1'b0;
   logic        reset   = 1'b1;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [15:0] held    = 16'h0000;   // bit r*4+c = key (r,c) held

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
      .clk_100 (clk_100),
      .reset   (reset),
      .ROW     (ROW),
      .COL     (COL),
      .kp      (kp)
   );

   always #5 clk_100 = ~clk_100;

   // Keypad: a held key shorts its row to its column while that column is low.
   always_comb begin
      ROW = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (|(held[r*4 +: 4] & ~COL)) ROW[r] = 1'b0;
      end
   end

   int checks = 0;
   int errors = 0;
   int vcount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] keycode(input int idx);
      case (idx)
         0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
         4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
         8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
        12: return 4'h0;  13: return 4'hF;  14: return 4'hE;  15: return 4'hD;
         default: return 4'h0;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   int          cyc = 0;           // cycle index since reset release
   bit          model_ready = 0;
   logic [15:0] hd1, hd2, acc;     // held one and two cycles ago; scan hit map
   bit          m_pressed;
   int          run, rel, ph, nh, kidx;
   logic [3:0]  cand;
   bit          acc_now;
   logic        exp_valid, exp_pressed;
   logic [3:0]  exp_code;
   logic [15:0] exp_value;

   initial begin
      forever begin
         @(posedge clk_100);
         if (reset) begin
            cyc = 0; hd1 = 0; hd2 = 0; acc = 0;
            m_pressed = 0; run = 0; rel = 0; cand = 0;
            exp_valid = 0; exp_code = 0; exp_pressed = 0; exp_value = 0;
            model_ready = 1;
         end else begin
            ph = cyc % SCAN;
            acc_now = 0;
            // Rows are seen through two flops: sample what was on the pads two cycles ago.
            if (ph % ST == ST - 1) begin
               for (int r = 0; r < 4; r++)
                  if (hd2[r*4 + ph/ST]) acc[r*4 + ph/ST] = 1'b1;
            end
            if (ph == SCAN - 1) begin
               nh = 0; kidx = 0;
               for (int i = 0; i < 16; i++) if (acc[i]) begin nh++; kidx = i; end
               if (!m_pressed) begin
                  if (nh == 1) begin
                     if (run > 0 && keycode(kidx) == cand) run++;
                     else begin cand = keycode(kidx); run = 1; end
                     if (run == DS) begin acc_now = 1; m_pressed = 1; run = 0; rel = 0; end
                  end else run = 0;
               end else begin
                  if (nh != 1) begin
                     rel++;
                     if (rel == DS) begin m_pressed = 0; rel = 0; end
                  end else rel = 0;
               end
               acc = 0;
            end
            exp_valid = acc_now;
            if (acc_now) exp_code = cand;
            if (kp.clear) exp_value = 16'h0000;
            else if (acc_now) exp_value = {exp_value[11:0], cand};
            exp_pressed = m_pressed;
            hd2 = hd1; hd1 = held;
            cyc++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [3:0] exp_col;
   initial begin
      forever begin
         @(negedge clk_100);
         if (model_ready) begin
            exp_col = ~(4'b0001 << ((cyc / ST) % 4));
            check("col",         32'(COL),            32'(exp_col));
            check("key_valid",   32'(kp.key_valid),   32'(exp_valid));
            check("key_code",    32'(kp.key_code),    32'(exp_code));
            check("key_pressed", 32'(kp.key_pressed), 32'(exp_pressed));
            check("value",       32'(kp.value),       32'(exp_value));
         end
      end
   end

   always @(posedge kp.key_valid) begin
      vcount++;
      $display("key accepted: code=%h value=%h cycle=%0d", kp.key_code, kp.value, cyc);
   end

   // ---------------- stimulus ----------------
   task automatic wait_scan_start();
      int i;
      for (i = 0; i < 2 * SCAN; i++) begin
         @(negedge clk_100);
         if (cyc % SCAN == 0) break;
      end
      check("scan_align", 32'(cyc % SCAN), 32'd0);
   endtask

   task automatic tap(input int idx);
      wait_scan_start();
      held = 16'(1) << idx;
      repeat (3 * SCAN) @(negedge clk_100);
      held = 16'h0000;
      repeat (3 * SCAN) @(negedge clk_100);
   endtask

   task automatic pulse_clear();
      kp.clear = 1'b1;
      @(negedge clk_100);
      kp.clear = 1'b0;
      @(negedge clk_100);
   endtask

   int vbase;
   int hold_len, gap_len;
   logic [15:0] m;
   int          seq_idx [5] = '{0, 3, 12, 13, 8};
   logic [15:0] seq_val [5] = '{16'h0001, 16'h001A, 16'h01A0, 16'h1A0F, 16'hA0F7};

   initial begin
      kp.clear = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk_100);
      reset = 1'b0;

      // 1: idle after reset, column rotation
      vbase = vcount;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_100);
         if (cyc == 1)  check("reset_col",   32'(COL), 32'hE);
         if (cyc == 1)  check("reset_value", 32'(kp.value), 32'h0);
         if (cyc == 8)  check("col1", 32'(COL), 32'hD);
         if (cyc == 16) check("col2", 32'(COL), 32'hB);
         if (cyc == 24) check("col3", 32'(COL), 32'h7);
      end
      check("idle_no_valid", 32'(vcount - vbase), 32'd0);

      // 2: single press of (r1,c2) = 6 and its release timing
      vbase = vcount;
      wait_scan_start();
      held = 16'(1) << 6;
      repeat (2 * SCAN) @(negedge clk_100);
      check("press6_valid",   32'(kp.key_valid),   32'd1);
      check("press6_code",    32'(kp.key_code),    32'h6);
      check("press6_value",   32'(kp.value),       32'h0006);
      check("press6_pressed", 32'(kp.key_pressed), 32'd1);
      held = 16'h0000;
      repeat (2 * SCAN - 1) @(negedge clk_100);
      check("rel6_still_held", 32'(kp.key_pressed), 32'd1);
      @(negedge clk_100);
      check("rel6_released", 32'(kp.key_pressed), 32'd0);
      check("press6_once", 32'(vcount - vbase), 32'd1);

      // 3: entry sequence 1, A, 0, F, 7
      pulse_clear();
      for (int i = 0; i < 5; i++) begin
         tap(seq_idx[i]);
         check("entry_value", 32'(kp.value), 32'(seq_val[i]));
      end

      // 4: bounce and glitch rejection
      vbase = vcount;
      wait_scan_start();
      held = 16'(1) << 9;
      repeat (SCAN) @(negedge clk_100);
      held = 16'h0000;
      repeat (3 * SCAN) @(negedge clk_100);
      check("one_scan_no_valid", 32'(vcount - vbase), 32'd0);
      wait_scan_start();
      for (int i = 0; i < 6; i++) begin
         held = 16'(1) << (i % 2);
         repeat (SCAN) @(negedge clk_100);
      end
      held = 16'h0000;
      repeat (3 * SCAN) @(negedge clk_100);
      check("toggle_no_valid", 32'(vcount - vbase), 32'd0);
      wait_scan_start();
      held = 16'h0021;
      repeat (5 * SCAN) @(negedge clk_100);
      held = 16'h0000;
      repeat (3 * SCAN) @(negedge clk_100);
      check("multi_no_valid", 32'(vcount - vbase), 32'd0);

      // 5: clear coinciding with accept, then clear alone
      pulse_clear();
      tap(0); tap(1); tap(2); tap(4);
      check("value_1234", 32'(kp.value), 32'h1234);
      wait_scan_start();
      held = 16'(1) << 15;
      repeat (2 * SCAN - 1) @(negedge clk_100);
      kp.clear = 1'b1;
      @(negedge clk_100);
      kp.clear = 1'b0;
      check("clrD_valid", 32'(kp.key_valid), 32'd1);
      check("clrD_code",  32'(kp.key_code),  32'hD);
      check("clrD_value", 32'(kp.value),     32'h0000);
      held = 16'h0000;
      repeat (3 * SCAN) @(negedge clk_100);
      tap(10);
      check("value_9", 32'(kp.value), 32'h0009);
      pulse_clear();
      check("clear_alone", 32'(kp.value), 32'h0000);
      tap(10);

      // 6: reset during PRESS_WAIT with key 5 held
      wait_scan_start();
      held = 16'(1) << 5;
      repeat (SCAN + 8) @(negedge clk_100);
      reset = 1'b1;
      @(negedge clk_100);
      reset = 1'b0;
      check("rst_col",     32'(COL),            32'hE);
      check("rst_valid",   32'(kp.key_valid),   32'd0);
      check("rst_code",    32'(kp.key_code),    32'h0);
      check("rst_pressed", 32'(kp.key_pressed), 32'd0);
      check("rst_value",   32'(kp.value),       32'h0000);
      repeat (2 * SCAN) @(negedge clk_100);
      check("redetect_valid", 32'(kp.key_valid), 32'd1);
      check("redetect_value", 32'(kp.value),     32'h0005);
      held = 16'h0000;
      repeat (3 * SCAN) @(negedge clk_100);

      // randomized presses, chords and clears, checked by the model
      for (int it = 0; it < 40; it++) begin
         m = 16'(1) << $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) m = m | (16'(1) << $urandom_range(0, 15));
         hold_len = $urandom_range(5, 130);
         gap_len  = $urandom_range(5, 130);
         held = m;
         for (int j = 0; j < hold_len; j++) begin
            @(negedge clk_100);
            kp.clear = ($urandom_range(0, 60) == 0);
         end
         held = 16'h0000;
         for (int j = 0; j < gap_len; j++) begin
            @(negedge clk_100);
            kp.clear = ($urandom_range(0, 60) == 0);
         end
      end
      kp.clear = 1'b0;
      repeat (4 * SCAN) @(negedge clk_100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex matrix keypad (Pmod KYPD on a Nexys-4 Pmod port) and turns debounced key presses into hex nibbles shifted into a 16-bit entry register. It is the input-side counterpart of the multiplexed 7-segment display path, and it is built from the same pieces: a time-multiplexed column strobe, active-low lines and a 16-bit register. Its `value` output feeds the display/register path in place of the LFSR data.

## Interface
- `SCAN_TICKS`, default 100_000: clock cycles each column stays driven (1 ms @ 100 MHz). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press or a release. Must be ≥ 1.

- `clk_100` — input, 1 bit: system clock, 100 MHz. Only clock.
- `reset` — input, 1 bit: **synchronous, active-high**.
- `ROW` — input, 4 bits: keypad rows, active-low (pulled up externally). Asynchronous to `clk_100`.
- `COL` — output, 4 bits: column strobes, active-low, exactly one bit low at all times.
- `clear` — input, 1 bit: synchronous clear of `value`.
- `key_valid` — output, 1 bit: one-cycle pulse on each accepted press.
- `key_code` — output, 4 bits: hex code of the last accepted key; held until the next accepted press.
- `key_pressed` — output, 1 bit: level, high while a debounced key is held.
- `value` — output, 16 bits: entry register; each new nibble is shifted in at the LSB end.

## Operation
- `ROW` passes through a 2-FF synchronizer before any use.
- **Column scan:** a tick counter runs 0..SCAN_TICKS-1, then the active column advances 0→1→2→3→0. `COL` = `~(4'b0001 << col)`.
- **Row sampling:** synchronized rows are sampled on the last tick of each column period.
- **Scan classification:** at the end of column 3, the full scan is classified as:
  - NONE: no rows are low;
  - SINGLE(code): exactly one row/column hit;
  - MULTI: two or more hits. MULTI is treated as NONE.
- **Key map** (row r, col c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- **Debounce FSM** (evaluated once per completed scan; a counter `n` counts matching scans):
  - **RELEASED:** on SINGLE(k), latch candidate k, set n=1, go to PRESS_WAIT. If DEBOUNCE_SCANS=1, accept immediately.
  - **PRESS_WAIT:**
    - SINGLE(same k): n++. When n reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - SINGLE(other): restart with the new candidate, n=1.
    - NONE: back to RELEASED.
  - **PRESSED:** `key_pressed`=1. On NONE, set n=1 and go to RELEASE_WAIT. SINGLE of any code, including a different key, is ignored.
  - **RELEASE_WAIT:**
    - NONE: n++. When n reaches DEBOUNCE_SCANS, go to RELEASED with `key_pressed`=0.
    - Any SINGLE: back to PRESSED.
- **Accept:** pulse `key_valid` for one cycle, set `key_code`=k, and set `value` = {value[11:0], k}. Auto-repeat is not supported: one press gives one pulse.
- **`clear`:** sets `value`=0. If `clear` coincides with an accept, clear wins (`value`=0). `key_valid` and `key_code` still update.
- **Reset** (overrides everything):
  - outputs: `COL`=4'b1110, `key_valid`=0, `key_code`=0, `key_pressed`=0, `value`=0;
  - internals: FSM=RELEASED, counters=0, synchronizer=4'b1111.

## Timing
- Full scan period: 4·SCAN_TICKS cycles. The first scan ends at cycle 4·SCAN_TICKS-1 after reset release.
- Rows reach the sampling point 2 cycles after the pad changes. A pad change settled ≥ 3 cycles before the last tick of a column is seen in that column.
- **Press latency:** `key_valid`, `key_code`, `value` and `key_pressed` update on the cycle after the end of the DEBOUNCE_SCANS-th consecutive matching scan.
- **Release:** `key_pressed` falls on the cycle after the end of the DEBOUNCE_SCANS-th consecutive NONE scan.
- Minimum gap between two `key_valid` pulses: 2·DEBOUNCE_SCANS scans.
- `value` holds its contents after a fifth nibble: the oldest nibble falls off the MSB end.
- Reset asserted mid-scan or mid-debounce: the next cycle shows the reset values, and the scan restarts at column 0.

## Structure
- **Shared package `keypad_pkg`:**
  - `scan_state_t` enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - scan-class enum (NONE, SINGLE, MULTI);
  - `KEYMAP` constant (16 × 4-bit, indexed {row, col}).
- **Sub-module `sync_2ff`:** parameterized-width two-flop synchronizer with synchronous reset value. Instantiated with width 4 and reset value 4'hF.
- Scan counter, classifier, FSM and shift register live in `keypad_scanner`.

## Test plan
Use SCAN_TICKS=8 and DEBOUNCE_SCANS=2 (one full scan = 32 cycles). The keypad model pulls `ROW[r]` low when `COL[c]` is low and key (r,c) is held.

1. **Reset:** after reset → `COL`=1110, `value`=0000, `key_pressed`=0, no `key_valid` for 200 cycles with no key held. Afterwards `COL` rotates 1110→1101→1011→0111 every 8 cycles.
2. **Single press:** hold (r1,c2) → exactly one `key_valid` with `key_code`=6 and `value`=0006, on the cycle after the 2nd full matching scan. Release → `key_pressed` falls 2 scans later.
3. **Entry sequence:** press/release keys 1, A, 0, F, 7 → `value` goes 0001, 001A, 01A0, 1A0F, A0F7.
4. **Bounce and glitch rejection:**
   - A key held for only one scan gives no `key_valid`.
   - A press that toggles (r0,c0)/(r0,c1) on alternate scans gives no `key_valid`.
   - Two keys held together (MULTI) give no `key_valid`.
5. **Clear:** with `value`=1234, `clear` pulsed on the same cycle as the accept of key D → `value`=0000, `key_valid`=1, `key_code`=D. A later `clear` alone gives 0000.
6. **Reset mid-operation:** reset asserted during PRESS_WAIT, with key 5 still held → all outputs return to reset values on the next cycle. The press is re-detected after 2 fresh scans with `value`=0005.
